// File: rtl/ssd_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ssd_scan_decoder
//  Description : Receive side of a 4-digit multiplexed seven-segment bus.
//                Registers the digit-select / segment buses, captures each
//                digit once it has been stable for STABLE_CYCLES samples,
//                decodes it to BCD (with blank / invalid flags) and publishes
//                a complete four-digit frame atomically. Flags loss of scan
//                when no digit is captured for TIMEOUT_CYCLES cycles.
//  Ports       : clk, rst (async, active-low)
//                ssd_ctrl[3:0]  active-low one-hot digit select
//                show[7:0]      active-low segments {a,b,c,d,e,f,g,dp}
//                value0..3[3:0] decoded digits of the last frame
//                digit_err/digit_blank[3:0]  per-digit flags of last frame
//                frame_valid, frame_changed  one-cycle commit pulses
//                scan_lost      level, no capture for TIMEOUT_CYCLES
//  Revision    : 1.0  initial release
// ============================================================================
module ssd_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ssd_ctrl,
    input  logic [7:0] show,
    output logic [3:0] value0,
    output logic [3:0] value1,
    output logic [3:0] value2,
    output logic [3:0] value3,
    output logic [3:0] digit_err,
    output logic [3:0] digit_blank,
    output logic       frame_valid,
    output logic       frame_changed,
    output logic       scan_lost
);

    localparam logic [7:0]       c_stable_m1 = 8'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(TIMEOUT_CYCLES);

    // Input sample and the sample before it
    logic [3:0]       r_s_ctrl, r_p_ctrl;
    logic [7:0]       r_s_show, r_p_show;
    logic [7:0]       r_stab_cnt;
    logic [CNT_W-1:0] r_to_cnt;
    logic             r_scan_lost;

    // Pending frame slots and published frame
    logic [3:0]  r_pend_mask;
    logic [15:0] r_pend_val;
    logic [3:0]  r_pend_err, r_pend_blank;
    logic [15:0] r_val;
    logic [3:0]  r_err, r_blank;
    logic        r_frame_valid, r_frame_changed;

    logic        w_same, w_legal, w_capture, w_commit, w_to_hit, w_lost_rise;
    logic [1:0]  w_digit;
    logic [7:0]  w_masked;
    logic [3:0]  w_nib;
    logic        w_err, w_blank;
    logic [7:0]  w_stab_nxt;
    logic [3:0]  w_mask_base;

    assign w_same = ({r_s_ctrl, r_s_show} == {r_p_ctrl, r_p_show});
    assign w_stab_nxt = !w_same ? 8'd1 :
                        (r_stab_cnt == 8'hFF) ? r_stab_cnt : r_stab_cnt + 8'd1;
    // Fires only on the edge where the count steps up to STABLE_CYCLES, so a
    // long dwell produces exactly one capture.
    assign w_capture = w_same && (r_stab_cnt == c_stable_m1) && w_legal;
    assign w_commit  = (r_pend_mask == 4'hF);
    assign w_to_hit  = (r_to_cnt == c_timeout);
    assign w_lost_rise = w_to_hit && !r_scan_lost;
    assign w_mask_base = (w_commit || w_lost_rise) ? 4'h0 : r_pend_mask;

    always_comb begin
        w_legal = 1'b0;
        w_digit = 2'd0;
        case (r_s_ctrl)
            4'b1110: begin w_legal = 1'b1; w_digit = 2'd0; end
            4'b1101: begin w_legal = 1'b1; w_digit = 2'd1; end
            4'b1011: begin w_legal = 1'b1; w_digit = 2'd2; end
            4'b0111: begin w_legal = 1'b1; w_digit = 2'd3; end
            default: begin w_legal = 1'b0; w_digit = 2'd0; end
        endcase
    end

    // Segment decode with the decimal point forced off
    assign w_masked = r_s_show | 8'h01;
    always_comb begin
        w_nib   = 4'hF;
        w_err   = 1'b0;
        w_blank = 1'b0;
        case (w_masked)
            8'h03: w_nib = 4'd0;
            8'h9F: w_nib = 4'd1;
            8'h25: w_nib = 4'd2;
            8'h0D: w_nib = 4'd3;
            8'h99: w_nib = 4'd4;
            8'h49: w_nib = 4'd5;
            8'h41: w_nib = 4'd6;
            8'h1F: w_nib = 4'd7;
            8'h01: w_nib = 4'd8;
            8'h09: w_nib = 4'd9;
            8'hFF: w_blank = 1'b1;
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s_ctrl        <= 4'hF;
            r_s_show        <= 8'hFF;
            r_p_ctrl        <= 4'hF;
            r_p_show        <= 8'hFF;
            r_stab_cnt      <= 8'd0;
            r_to_cnt        <= '0;
            r_scan_lost     <= 1'b0;
            r_pend_mask     <= 4'h0;
            r_pend_val      <= 16'h0;
            r_pend_err      <= 4'h0;
            r_pend_blank    <= 4'h0;
            r_val           <= 16'h0;
            r_err           <= 4'h0;
            r_blank         <= 4'h0;
            r_frame_valid   <= 1'b0;
            r_frame_changed <= 1'b0;
        end else begin
            r_s_ctrl   <= ssd_ctrl;
            r_s_show   <= show;
            r_p_ctrl   <= r_s_ctrl;
            r_p_show   <= r_s_show;
            r_stab_cnt <= w_stab_nxt;

            r_to_cnt    <= w_capture ? '0 : (w_to_hit ? r_to_cnt : r_to_cnt + CNT_W'(1));
            r_scan_lost <= w_to_hit;

            // Outputs take the slot contents as they stood before this edge,
            // so a capture on the commit edge belongs to the next frame.
            r_frame_valid   <= w_commit;
            r_frame_changed <= w_commit &&
                ({r_pend_val, r_pend_err, r_pend_blank} != {r_val, r_err, r_blank});
            if (w_commit) begin
                r_val   <= r_pend_val;
                r_err   <= r_pend_err;
                r_blank <= r_pend_blank;
            end

            r_pend_mask <= w_mask_base | (w_capture ? ~r_s_ctrl : 4'h0);
            if (w_capture) begin
                r_pend_val[{w_digit, 2'b00} +: 4] <= w_nib;
                r_pend_err[w_digit]               <= w_err;
                r_pend_blank[w_digit]             <= w_blank;
            end
        end
    end

    assign value0        = r_val[3:0];
    assign value1        = r_val[7:4];
    assign value2        = r_val[11:8];
    assign value3        = r_val[15:12];
    assign digit_err     = r_err;
    assign digit_blank   = r_blank;
    assign frame_valid   = r_frame_valid;
    assign frame_changed = r_frame_changed;
    assign scan_lost     = r_scan_lost;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ssd_scan_decoder
//  Description : Self-checking bench for ssd_scan_decoder. A reference model
//                built on the applied-input history predicts every output
//                cycle by cycle; directed steps add explicit spot checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ssd_scan_decoder;

    localparam int S = 4;
    localparam int T = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ssd_ctrl = 4'hF;
    logic [7:0] show = 8'hFF;
    logic [3:0] value0, value1, value2, value3, digit_err, digit_blank;
    logic       frame_valid, frame_changed, scan_lost;

    ssd_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(9)) dut (
        .clk(clk), .rst(rst), .ssd_ctrl(ssd_ctrl), .show(show),
        .value0(value0), .value1(value1), .value2(value2), .value3(value3),
        .digit_err(digit_err), .digit_blank(digit_blank),
        .frame_valid(frame_valid), .frame_changed(frame_changed),
        .scan_lost(scan_lost)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int fv_seen = 0;
    logic fc_last = 1'b0;

    logic [7:0] seg_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    // Reference model state
    logic [11:0] hist [$];
    logic [3:0]  m_val [4];
    logic [3:0]  p_val [4];
    logic [3:0]  m_err, m_blank, p_err, p_blank, m_mask;
    logic        m_fv, m_fc, m_lost;
    int          m_since;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void decode(input logic [7:0] sh, output logic [3:0] nib,
                                   output logic e, output logic b);
        nib = 4'hF; e = 1'b0; b = 1'b0;
        if ((sh | 8'h01) == 8'hFF) b = 1'b1;
        else begin
            e = 1'b1;
            for (int i = 0; i < 10; i++)
                if ((sh | 8'h01) == seg_tab[i]) begin nib = 4'(i); e = 1'b0; end
        end
    endfunction

    // Length of the run of identical samples ending at the newest sample
    function automatic int run_len();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin m_val[i] = 4'h0; p_val[i] = 4'h0; end
        m_err = 0; m_blank = 0; p_err = 0; p_blank = 0; m_mask = 0;
        m_fv = 0; m_fc = 0; m_lost = 0; m_since = 0;
        hist.delete();
        hist.push_back(12'hFFF);
    endtask

    task automatic model_edge(input logic [3:0] c, input logic [7:0] sh);
        logic [11:0] cur;
        logic        cap, commit, lost_rise, e, b;
        logic [3:0]  nib;
        int          d;
        cur = hist[hist.size() - 1];
        d = 0;
        for (int i = 0; i < 4; i++) if (cur[11:8] == ~(4'b0001 << i)) d = i;
        cap = (run_len() == S) && $onehot(~cur[11:8]);
        commit = (m_mask == 4'hF);
        lost_rise = (m_since >= T) && !m_lost;
        m_fv = commit;
        m_fc = 1'b0;
        if (commit) begin
            for (int i = 0; i < 4; i++) if (p_val[i] != m_val[i]) m_fc = 1'b1;
            if (p_err != m_err || p_blank != m_blank) m_fc = 1'b1;
            for (int i = 0; i < 4; i++) m_val[i] = p_val[i];
            m_err = p_err; m_blank = p_blank;
        end
        if (commit || lost_rise) m_mask = 4'h0;
        if (cap) begin
            decode(cur[7:0], nib, e, b);
            p_val[d] = nib; p_err[d] = e; p_blank[d] = b;
            m_mask[d] = 1'b1;
        end
        m_lost  = (m_since >= T);
        m_since = cap ? 0 : ((m_since >= T) ? T : m_since + 1);
        hist.push_back({c, sh});
        if (hist.size() > 400) void'(hist.pop_front());
    endtask

    task automatic step(input logic [3:0] c, input logic [7:0] sh);
        ssd_ctrl = c;
        show = sh;
        @(posedge clk);
        model_edge(c, sh);
        #1;
        check("cycle",
              {5'd0, value3, value2, value1, value0, digit_err, digit_blank,
               frame_valid, frame_changed, scan_lost},
              {5'd0, m_val[3], m_val[2], m_val[1], m_val[0], m_err, m_blank,
               m_fv, m_fc, m_lost});
        if (frame_valid) begin fv_seen++; fc_last = frame_changed; end
    endtask

    task automatic dwell(input logic [3:0] c, input logic [7:0] sh, input int n);
        for (int i = 0; i < n; i++) step(c, sh);
    endtask

    task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3, input int n);
        dwell(4'b1110, s0, n);
        dwell(4'b1101, s1, n);
        dwell(4'b1011, s2, n);
        dwell(4'b0111, s3, n);
        dwell(4'hF, 8'hFF, 2);
    endtask

    logic [3:0] rc;
    logic [7:0] rs;
    int         rr;

    initial begin
        model_reset();
        #12;
        check("reset_state",
              {5'd0, value3, value2, value1, value0, digit_err, digit_blank,
               frame_valid, frame_changed, scan_lost}, 32'd0);
        rst = 1'b1;

        // First frame: 0,0,0,1
        fv_seen = 0;
        scan(8'h9F, 8'h03, 8'h03, 8'h03, 8);
        check("tp1_values", {16'd0, value3, value2, value1, value0}, 32'h0001);
        check("tp1_err", {28'd0, digit_err}, 32'd0);
        check("tp1_fv_count", fv_seen, 1);
        check("tp1_changed", {31'd0, fc_last}, 1);

        // Identical frame, then digit0 -> 2
        fv_seen = 0;
        scan(8'h9F, 8'h03, 8'h03, 8'h03, 8);
        check("tp2_fv_count", fv_seen, 1);
        check("tp2_unchanged", {31'd0, fc_last}, 0);
        scan(8'h25, 8'h03, 8'h03, 8'h03, 8);
        check("tp2_value0", {28'd0, value0}, 2);
        check("tp2_changed", {31'd0, fc_last}, 1);

        // Dwell too short: nothing captured
        fv_seen = 0;
        scan(8'h99, 8'h49, 8'h41, 8'h1F, S - 1);
        check("short_dwell_fv", fv_seen, 0);

        // Segment change one cycle into the dwell restarts stability
        fv_seen = 0;
        dwell(4'b1110, 8'h99, 1);
        dwell(4'b1110, 8'h49, 8);
        scan(8'h49, 8'h0D, 8'h01, 8'h09, 8);
        check("restart_value0", {28'd0, value0}, 5);

        // Blank and invalid digits
        scan(8'h03, 8'h55, 8'hFF, 8'h25, 8);
        check("blank_flags", {28'd0, digit_blank}, 32'b0100);
        check("err_flags", {28'd0, digit_err}, 32'b0010);
        check("v2_v1", {24'd0, value2, value1}, 32'hFF);

        // Decimal point ignored
        scan(8'h9E, 8'h03, 8'h03, 8'h03, 8);
        check("dp_value0", {28'd0, value0}, 1);
        check("dp_err", {28'd0, digit_err}, 0);

        // Timeout discards partial frame
        dwell(4'b1110, 8'h03, 8);
        dwell(4'b1101, 8'h9F, 8);
        dwell(4'hF, 8'hFF, T + 10);
        check("scan_lost_set", {31'd0, scan_lost}, 1);
        fv_seen = 0;
        scan(8'h1F, 8'h01, 8'h09, 8'h41, 8);
        check("scan_lost_clr", {31'd0, scan_lost}, 0);
        check("after_lost_fv", fv_seen, 1);

        // Randomized scans
        for (int it = 0; it < 40; it++) begin
            for (int d = 0; d < 4; d++) begin
                rr = int'($urandom_range(0, 9));
                rc = (rr == 0) ? 4'($urandom) : ~(4'b0001 << d);
                rs = (rr < 3) ? 8'($urandom)
                              : (seg_tab[$urandom_range(0, 9)] & {7'h7F, 1'($urandom)});
                dwell(rc, rs, int'($urandom_range(2, 8)));
            end
        end

        // Asynchronous reset mid-frame
        scan(8'h03, 8'h03, 8'h03, 8'h03, 8);
        dwell(4'b1110, 8'h9F, 8);
        dwell(4'b1101, 8'h25, 8);
        dwell(4'b1011, 8'h0D, 8);
        #2 rst = 1'b0;
        #1;
        check("async_reset",
              {5'd0, value3, value2, value1, value0, digit_err, digit_blank,
               frame_valid, frame_changed, scan_lost}, 32'd0);
        model_reset();
        ssd_ctrl = 4'hF;
        show = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        fv_seen = 0;
        dwell(4'b0111, 8'h99, 8);
        dwell(4'hF, 8'hFF, 4);
        check("partial_no_fv", fv_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ssd_scan_decoder.md
Name: ssd_scan_decoder

Overview:
- Receive end of the 4-digit multiplexed seven-segment interface driven by the counter/display path.
- Watches the digit-select and segment buses, rebuilds the four BCD digits, and flags invalid or blank patterns.
- Publishes each complete scan frame atomically.
- Used for on-board self-check and as the bench monitor for display-driving blocks.

Parameters:
- STABLE_CYCLES, 4: consecutive identical registered samples required before a digit is captured. Legal range 2..255.
- TIMEOUT_CYCLES, 100000: cycles without any capture before scan_lost asserts.
- CNT_W, 17: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ssd_ctrl  in  4  digit select, active-low one-hot. 4'b1110 = digit0 (rightmost), 4'b1101 = digit1, 4'b1011 = digit2, 4'b0111 = digit3.
- show  in  8  segment pattern, active-low (0 = lit). Bit order {a,b,c,d,e,f,g,dp}.
- value0..value3  out  4 each  decoded digits of the last complete frame.
- digit_err  out  4  per-digit invalid-pattern flags for the last frame.
- digit_blank  out  4  per-digit blank flags (pattern 8'hFF, dp ignored) for the last frame.
- frame_valid  out  1  one-cycle pulse when the frame outputs update.
- frame_changed  out  1  one-cycle pulse, coincident with frame_valid, when any value/err/blank bit differs from the previous frame.
- scan_lost  out  1  level: no capture for TIMEOUT_CYCLES.

Behaviour:
- Reset (rst low, asynchronous):
  - value0..3 = 4'd0; digit_err = 0; digit_blank = 0.
  - frame_valid = 0; frame_changed = 0; scan_lost = 0.
  - Input registers cleared to ctrl = 4'hF, show = 8'hFF.
  - Pending mask, pending digits, stability counter and timeout counter all cleared.
- Input stage: ssd_ctrl and show registered every clk (s_ctrl, s_show).
- Stability counter:
  - Compares {s_ctrl, s_show} with its previous value. Equal: saturating increment. Different: reset to 1.
  - The capture edge is the edge where the counter reaches STABLE_CYCLES while s_ctrl is a legal one-hot-low code.
  - Exactly one capture per dwell. No recapture until the sample changes.
  - Input-to-capture latency = 1 + STABLE_CYCLES edges.
- Non-one-hot s_ctrl (4'hF, multi-hot): no capture. The stability counter still runs.
- Decode, masked with dp ignored:
  - Digits 0..9: 0x03, 0x9F, 0x25, 0x0D, 0x99, 0x49, 0x41, 0x1F, 0x01, 0x09 (dp bit taken as 1).
  - 8'hFF (masked): blank, nibble 4'hF, blank = 1.
  - Any other pattern: nibble 4'hF, err = 1.
- Pending frame:
  - A capture writes {nibble, err, blank} into the pending slot for that digit and sets its pending-mask bit.
  - A re-capture of an already-pending digit overwrites that slot (latest wins).
- Frame commit:
  - On the edge after the capture that makes the pending mask 4'hF, all four slots copy to the outputs simultaneously.
  - frame_valid = 1 for that one cycle; frame_changed is evaluated against the prior outputs in the same cycle.
  - The pending mask clears on the commit edge.
  - A capture landing on the commit edge counts toward the next frame.
- Timeout:
  - The counter clears on every capture and otherwise increments, saturating.
  - scan_lost = 1 once the count reaches TIMEOUT_CYCLES.
  - scan_lost clears on the edge after the next capture.
  - The pending mask is cleared when scan_lost rises, so a partial frame is discarded.
- Reset mid-frame: all pending state is lost and outputs return to reset values. No frame_valid is emitted for a partial frame.
- Frame outputs are never partially updated.

Test Plan:
- Reset, then scan 1110/0x9F, 1101/0x03, 1011/0x03, 0111/0x03, each held 8 cycles -> frame_valid pulse once; value3..0 = 0,0,0,1; digit_err = 0; frame_changed = 1.
- Repeat the identical scan -> frame_valid pulses, frame_changed = 0. Then change digit0 to 0x25 -> next frame has value0 = 2 and frame_changed = 1.
- Hold each digit only STABLE_CYCLES-1 = 3 cycles -> no capture, no frame_valid.
- After 1 cycle, change show within the dwell -> capture 1+STABLE_CYCLES edges after the change.
- Digit2 = 0xFF and digit1 = 0x55 -> digit_blank = 4'b0100, digit_err = 4'b0010, value2 = value1 = 4'hF.
- Pass 0x9E (dp lit) -> decodes as 1, no error.
- Capture digits 0 and 1, then hold ssd_ctrl = 4'hF for TIMEOUT_CYCLES -> scan_lost = 1 and the partial frame is discarded. Next full scan -> scan_lost = 0 and frame_valid pulses.
- Pulse rst low asynchronously after three digits are captured -> outputs return to 0 immediately. A fourth digit alone does not produce frame_valid.
